// File: rtl/ehl_ddr_phy_rdlvl_ctrl.sv
// -----------------------------------------------------------------------------
// ehl_ddr_phy_rdlvl_ctrl
//
// Multi-lane read-leveling trainer for the DDR PHY DLL delay lines. A run
// sweeps every tap of either the DQS delay bus (data mode) or the gate delay
// bus (gate mode) on all byte lanes at once, issues SAMPLES training reads per
// tap and scores each lane from the per-lane read responses. At the end each
// lane is programmed with the centre of its first passing window (data mode)
// or with the first passing tap (gate mode). Lanes that never pass, or every
// lane on a read timeout, are flagged in error and get their pre-run code back.
//
// Ports
//   clk            controller clock
//   reset          asynchronous, active-high reset
//   start          start a run (sampled only while idle)
//   mode           0 = data-eye (DQS) training, 1 = gate training; latched at start
//   rd_req         training read request, held until rd_ack
//   rd_ack         read done; rd_resp is valid in the same cycle
//   rd_resp        per-lane pass flag for the acknowledged read
//   rdlvl_delay    per-lane DQS delay codes, lane i at [i*DLY_W +: DLY_W]
//   rdlvl_gate_dly per-lane gate delay codes, same packing
//   rdlvl_gate_en  high throughout a gate-mode run
//   busy           run in progress
//   done           one-cycle pulse at the end of a run
//   error          per-lane failure flags, valid from done until the next start
// -----------------------------------------------------------------------------
module ehl_ddr_phy_rdlvl_ctrl #(
    parameter int LANES   = 2,
    parameter int DLY_W   = 3,
    parameter int SAMPLES = 2,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64,
    parameter int DEFAULT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    output logic                   rd_req,
    input  logic                   rd_ack,
    input  logic [LANES-1:0]       rd_resp,
    output logic [LANES*DLY_W-1:0] rdlvl_delay,
    output logic [LANES*DLY_W-1:0] rdlvl_gate_dly,
    output logic                   rdlvl_gate_en,
    output logic                   busy,
    output logic                   done,
    output logic [LANES-1:0]       error
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int SMP_W = $clog2(SAMPLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [DLY_W-1:0] TAP_MAX     = '1;
    localparam logic [DLY_W-1:0] TAP_DEFAULT = DLY_W'(DEFAULT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_CALC,
        S_DONE
    } state_t;

    state_t                         state_reg;
    logic                           mode_reg;
    logic [DLY_W-1:0]               tap_reg;
    logic [SET_W-1:0]               settle_cnt_reg;
    logic [SMP_W-1:0]               sample_cnt_reg;
    logic [TMO_W-1:0]               wait_cnt_reg;
    logic [LANES-1:0]               tap_pass_reg;
    logic [LANES-1:0]               found_reg;
    logic [LANES-1:0]               closed_reg;
    logic [LANES-1:0][DLY_W-1:0]    lo_reg;
    logic [LANES-1:0][DLY_W-1:0]    hi_reg;
    logic [LANES-1:0][DLY_W-1:0]    delay_reg;
    logic [LANES-1:0][DLY_W-1:0]    gate_reg;
    logic [LANES-1:0][DLY_W-1:0]    saved_reg;
    logic [LANES-1:0][DLY_W-1:0]    mid;
    logic                           rd_req_reg;
    logic                           busy_reg;
    logic                           done_reg;
    logic [LANES-1:0]               error_reg;

    // Window centre per lane; the sum carries one extra bit so lo+hi never
    // overflows before the floor division.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DLY_W:0] sum;
            assign sum     = {1'b0, lo_reg[gi]} + {1'b0, hi_reg[gi]};
            assign mid[gi] = sum[DLY_W:1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            mode_reg       <= 1'b0;
            tap_reg        <= '0;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            tap_pass_reg   <= '0;
            found_reg      <= '0;
            closed_reg     <= '0;
            rd_req_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= '0;
            for (int i = 0; i < LANES; i++) begin
                lo_reg[i]    <= '0;
                hi_reg[i]    <= '0;
                delay_reg[i] <= TAP_DEFAULT;
                gate_reg[i]  <= TAP_DEFAULT;
                saved_reg[i] <= TAP_DEFAULT;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg       <= mode;
                        tap_reg        <= '0;
                        found_reg      <= '0;
                        closed_reg     <= '0;
                        error_reg      <= '0;
                        tap_pass_reg   <= '1;
                        settle_cnt_reg <= '0;
                        sample_cnt_reg <= '0;
                        busy_reg       <= 1'b1;
                        for (int i = 0; i < LANES; i++) begin
                            lo_reg[i]    <= '0;
                            hi_reg[i]    <= '0;
                            // Snapshot the bus this run will overwrite so a
                            // failed lane can be put back.
                            saved_reg[i] <= mode ? gate_reg[i] : delay_reg[i];
                        end
                        state_reg <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (mode_reg) gate_reg[i]  <= tap_reg;
                        else          delay_reg[i] <= tap_reg;
                    end
                    if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
                        state_reg <= S_REQ;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end

                S_REQ: begin
                    rd_req_reg   <= 1'b1;
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end

                S_WAIT: begin
                    if (rd_ack) begin
                        // Dropping rd_req here and re-raising it from S_REQ
                        // guarantees a low cycle between reads.
                        rd_req_reg   <= 1'b0;
                        tap_pass_reg <= tap_pass_reg & rd_resp;
                        if (sample_cnt_reg == SMP_W'(SAMPLES - 1)) begin
                            state_reg <= S_EVAL;
                        end else begin
                            sample_cnt_reg <= sample_cnt_reg + 1'b1;
                            state_reg      <= S_REQ;
                        end
                    end else if (wait_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
                        rd_req_reg <= 1'b0;
                        error_reg  <= '1;
                        for (int i = 0; i < LANES; i++) begin
                            if (mode_reg) gate_reg[i]  <= saved_reg[i];
                            else          delay_reg[i] <= saved_reg[i];
                        end
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                S_EVAL: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (tap_pass_reg[i]) begin
                            if (!found_reg[i]) begin
                                found_reg[i] <= 1'b1;
                                lo_reg[i]    <= tap_reg;
                                hi_reg[i]    <= tap_reg;
                            end else if (!closed_reg[i]) begin
                                hi_reg[i] <= tap_reg;
                            end
                        end else if (found_reg[i]) begin
                            // A fail after the window opened closes it for
                            // good; later passing taps are ignored.
                            closed_reg[i] <= 1'b1;
                        end
                    end
                    if (tap_reg == TAP_MAX) begin
                        state_reg <= S_CALC;
                    end else begin
                        tap_reg        <= tap_reg + 1'b1;
                        settle_cnt_reg <= '0;
                        sample_cnt_reg <= '0;
                        tap_pass_reg   <= '1;
                        state_reg      <= S_SETTLE;
                    end
                end

                S_CALC: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (found_reg[i]) begin
                            if (mode_reg) gate_reg[i]  <= lo_reg[i];
                            else          delay_reg[i] <= mid[i];
                        end else begin
                            error_reg[i] <= 1'b1;
                            if (mode_reg) gate_reg[i]  <= saved_reg[i];
                            else          delay_reg[i] <= saved_reg[i];
                        end
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_DONE;
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req         = rd_req_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;
    assign rdlvl_delay    = delay_reg;
    assign rdlvl_gate_dly = gate_reg;
    // Gate enable tracks the run so the DLL masks dqs_90 only while gate
    // training is actually sweeping.
    assign rdlvl_gate_en  = busy_reg & mode_reg;

endmodule

// File: tb/tb_ehl_ddr_phy_rdlvl_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for ehl_ddr_phy_rdlvl_ctrl (LANES=2, DLY_W=3, SAMPLES=2).
// A responder answers training reads from a per-lane/per-tap/per-sample pass
// table; a reference model derives expected codes and error flags from the
// same table by locating each lane's first run of fully passing taps.
// -----------------------------------------------------------------------------
module tb_ehl_ddr_phy_rdlvl_ctrl;

    localparam int LANES   = 2;
    localparam int DLY_W   = 3;
    localparam int SAMPLES = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int NTAPS   = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   mode;
    logic                   rd_ack;
    logic [LANES-1:0]       rd_resp;
    logic                   rd_req;
    logic [LANES*DLY_W-1:0] rdlvl_delay;
    logic [LANES*DLY_W-1:0] rdlvl_gate_dly;
    logic                   rdlvl_gate_en;
    logic                   busy;
    logic                   done;
    logic [LANES-1:0]       error;

    ehl_ddr_phy_rdlvl_ctrl #(
        .LANES(LANES), .DLY_W(DLY_W), .SAMPLES(SAMPLES),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .DEFAULT(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_resp(rd_resp),
        .rdlvl_delay(rdlvl_delay), .rdlvl_gate_dly(rdlvl_gate_dly),
        .rdlvl_gate_en(rdlvl_gate_en), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    bit pass_tbl [LANES][NTAPS][SAMPLES];
    int total = 0;
    int bad   = 0;
    int exp_dly  [LANES];
    int exp_gate [LANES];

    // Results of the latest run
    int               r_done_cnt, r_reads, r_tap_bad, r_gate_bad, r_busy_bad;
    int               r_req_cyc, r_done_cyc;
    bit               r_hung;
    logic [LANES-1:0] r_error;

    function automatic bit tap_ok(input int l, input int t);
        bit p = 1'b1;
        for (int s = 0; s < SAMPLES; s++) p &= pass_tbl[l][t][s];
        return p;
    endfunction

    task automatic set_window(input int l, input int lo, input int hi);
        for (int t = 0; t < NTAPS; t++)
            for (int s = 0; s < SAMPLES; s++)
                pass_tbl[l][t][s] = (t >= lo && t <= hi);
    endtask

    // Reference: first passing tap opens the window, it extends over the
    // following consecutive passing taps; centre (floor) or first tap.
    task automatic model_run(input bit m, output logic [LANES-1:0] e_err);
        e_err = '0;
        for (int l = 0; l < LANES; l++) begin
            int lo, hi;
            lo = -1;
            for (int t = NTAPS - 1; t >= 0; t--) if (tap_ok(l, t)) lo = t;
            if (lo < 0) begin
                e_err[l] = 1'b1;
            end else begin
                hi = lo;
                while (hi + 1 < NTAPS && tap_ok(l, hi + 1)) hi++;
                if (m) exp_gate[l] = lo;
                else   exp_dly[l]  = (lo + hi) / 2;
            end
        end
    endtask

    // Starts a run and services reads until done (+3 cycles). abort_read >= 0
    // returns while that read is pending and unanswered.
    task automatic run_training(input bit m, input bit ack_on, input int abort_read,
                                input bit poke);
        int k, dly, cyc, tap, smp;
        bit finished;
        k = 0; cyc = 0; finished = 1'b0; dly = $urandom_range(0, 3);
        r_done_cnt = 0; r_tap_bad = 0; r_gate_bad = 0; r_busy_bad = 0;
        r_req_cyc = -1; r_done_cyc = -1; r_hung = 1'b0;
        @(posedge clk); #1; start = 1'b1; mode = m;
        @(posedge clk); #1; start = 1'b0; mode = ~m;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise got=%b want=1", busy);
        end
        while (!finished) begin
            if (rdlvl_gate_en !== (busy & m)) r_gate_bad++;
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
                if (busy !== 1'b0) r_busy_bad++;
            end
            if (rd_req === 1'b1 && r_req_cyc < 0) r_req_cyc = cyc;
            if (rd_ack) begin
                rd_ack  = 1'b0;
                rd_resp = LANES'($urandom);
            end else if (rd_req === 1'b1 && ack_on) begin
                if (k == abort_read) begin
                    finished = 1'b1;
                end else if (dly == 0) begin
                    tap = k / SAMPLES;
                    smp = k % SAMPLES;
                    for (int l = 0; l < LANES; l++) begin
                        rd_resp[l] = pass_tbl[l][tap][smp];
                        if ((m ? rdlvl_gate_dly[l*DLY_W +: DLY_W]
                               : rdlvl_delay[l*DLY_W +: DLY_W]) !== DLY_W'(tap))
                            r_tap_bad++;
                    end
                    rd_ack = 1'b1;
                    k++;
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end else if (rd_req === 1'b0 && $urandom_range(0, 7) == 0) begin
                // Stray ack with no request pending must be ignored
                rd_ack  = 1'b1;
                rd_resp = LANES'($urandom);
            end
            start = (poke && cyc == 20);
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 3) finished = 1'b1;
            if (cyc >= 4000) begin
                finished = 1'b1;
                r_hung   = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        rd_ack = 1'b0;
        start  = 1'b0;
        r_reads = k;
        r_error = error;
        $display("run mode=%0d reads=%0d done_cnt=%0d error=%b delay=%h gate=%h",
                 m, k, r_done_cnt, error, rdlvl_delay, rdlvl_gate_dly);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = 1'b0; rd_ack = 1'b0; rd_resp = '0;
        for (int l = 0; l < LANES; l++) begin exp_dly[l] = 0; exp_gate[l] = 0; end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rd_req, busy, done, rdlvl_gate_en, error, rdlvl_delay, rdlvl_gate_dly} !== '0) begin
            bad++;
            $display("FAIL reset_values got req=%b busy=%b done=%b gen=%b err=%b dly=%h gate=%h want all 0",
                     rd_req, busy, done, rdlvl_gate_en, error, rdlvl_delay, rdlvl_gate_dly);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_data_window;
        logic [LANES-1:0] e_err;
        set_window(0, 2, 5);
        set_window(1, 3, 7);
        model_run(1'b0, e_err);
        run_training(1'b0, 1'b1, -1, 1'b0);
        total += 5;
        if (rdlvl_delay !== {3'd5, 3'd3}) begin bad++; $display("FAIL data_codes got=%h want=%h", rdlvl_delay, {3'd5, 3'd3}); end
        if (r_error !== e_err || e_err !== 2'b00) begin bad++; $display("FAIL data_error got=%b want=00", r_error); end
        if (r_done_cnt !== 1 || r_busy_bad !== 0 || r_hung) begin bad++; $display("FAIL data_done got=%0d busy_bad=%0d want=1,0", r_done_cnt, r_busy_bad); end
        if (r_reads !== NTAPS * SAMPLES || r_tap_bad !== 0) begin bad++; $display("FAIL data_sweep reads=%0d tap_bad=%0d want=%0d,0", r_reads, r_tap_bad, NTAPS * SAMPLES); end
        if (r_gate_bad !== 0) begin bad++; $display("FAIL data_gate_en got=%0d bad cycles want=0", r_gate_bad); end
    endtask

    task automatic test_gate_window;
        logic [LANES-1:0] e_err;
        set_window(0, 4, 7);
        set_window(1, 1, 6);
        model_run(1'b1, e_err);
        run_training(1'b1, 1'b1, -1, 1'b0);
        total += 5;
        if (rdlvl_gate_dly !== {3'd1, 3'd4}) begin bad++; $display("FAIL gate_codes got=%h want=%h", rdlvl_gate_dly, {3'd1, 3'd4}); end
        if (rdlvl_delay !== {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])}) begin bad++; $display("FAIL gate_delay_held got=%h want=%h", rdlvl_delay, {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])}); end
        if (r_gate_bad !== 0) begin bad++; $display("FAIL gate_en_track got=%0d bad cycles want=0", r_gate_bad); end
        if (r_error !== e_err || r_done_cnt !== 1) begin bad++; $display("FAIL gate_done err=%b done_cnt=%0d want=%b,1", r_error, r_done_cnt, e_err); end
        if (r_reads !== NTAPS * SAMPLES || r_tap_bad !== 0) begin bad++; $display("FAIL gate_sweep reads=%0d tap_bad=%0d", r_reads, r_tap_bad); end
    endtask

    task automatic test_lane_fail;
        logic [LANES-1:0] e_err;
        set_window(0, 0, 6);
        set_window(1, 9, 0);
        model_run(1'b0, e_err);
        run_training(1'b0, 1'b1, -1, 1'b0);
        total += 3;
        if (r_error !== 2'b10 || e_err !== 2'b10) begin bad++; $display("FAIL lane_fail_error got=%b want=10", r_error); end
        if (rdlvl_delay[DLY_W +: DLY_W] !== DLY_W'(exp_dly[1])) begin bad++; $display("FAIL lane_fail_restore got=%0d want=%0d", rdlvl_delay[DLY_W +: DLY_W], exp_dly[1]); end
        if (rdlvl_delay[0 +: DLY_W] !== 3'd3) begin bad++; $display("FAIL lane_fail_centre got=%0d want=3", rdlvl_delay[0 +: DLY_W]); end
    endtask

    task automatic test_timeout;
        run_training(1'b0, 1'b0, -1, 1'b0);
        total += 4;
        if (r_done_cyc - r_req_cyc !== TIMEOUT || r_req_cyc < 0) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", r_done_cyc - r_req_cyc, TIMEOUT); end
        if (r_error !== 2'b11) begin bad++; $display("FAIL timeout_error got=%b want=11", r_error); end
        if (rdlvl_delay !== {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])} ||
            rdlvl_gate_dly !== {DLY_W'(exp_gate[1]), DLY_W'(exp_gate[0])}) begin
            bad++; $display("FAIL timeout_codes got=%h/%h want=%h/%h", rdlvl_delay, rdlvl_gate_dly,
                            {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])}, {DLY_W'(exp_gate[1]), DLY_W'(exp_gate[0])});
        end
        if (r_done_cnt !== 1 || rd_req !== 1'b0) begin bad++; $display("FAIL timeout_done done_cnt=%0d req=%b want=1,0", r_done_cnt, rd_req); end
    endtask

    task automatic test_first_window;
        logic [LANES-1:0] e_err;
        set_window(0, 1, 2);
        pass_tbl[0][5][0] = 1'b1; pass_tbl[0][5][1] = 1'b1;
        pass_tbl[0][6][0] = 1'b1; pass_tbl[0][6][1] = 1'b1;
        pass_tbl[0][3][0] = 1'b1; pass_tbl[0][3][1] = 1'b0;
        set_window(1, 0, 7);
        model_run(1'b0, e_err);
        run_training(1'b0, 1'b1, -1, 1'b0);
        total += 2;
        if (rdlvl_delay[0 +: DLY_W] !== 3'd1) begin bad++; $display("FAIL first_window got=%0d want=1", rdlvl_delay[0 +: DLY_W]); end
        if (rdlvl_delay[DLY_W +: DLY_W] !== 3'd3 || r_error !== e_err) begin bad++; $display("FAIL first_window_lane1 got=%0d err=%b want=3,%b", rdlvl_delay[DLY_W +: DLY_W], r_error, e_err); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            logic [LANES-1:0] e_err;
            bit m;
            m = 1'($urandom);
            for (int l = 0; l < LANES; l++)
                for (int t = 0; t < NTAPS; t++)
                    for (int s = 0; s < SAMPLES; s++)
                        pass_tbl[l][t][s] = ($urandom_range(0, 9) < 7);
            model_run(m, e_err);
            run_training(m, 1'b1, -1, 1'b0);
            total += 4;
            if (r_error !== e_err) begin bad++; $display("FAIL rand_error n=%0d got=%b want=%b", n, r_error, e_err); end
            if (rdlvl_delay !== {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])}) begin bad++; $display("FAIL rand_delay n=%0d got=%h want=%h", n, rdlvl_delay, {DLY_W'(exp_dly[1]), DLY_W'(exp_dly[0])}); end
            if (rdlvl_gate_dly !== {DLY_W'(exp_gate[1]), DLY_W'(exp_gate[0])}) begin bad++; $display("FAIL rand_gate n=%0d got=%h want=%h", n, rdlvl_gate_dly, {DLY_W'(exp_gate[1]), DLY_W'(exp_gate[0])}); end
            if (r_done_cnt !== 1 || r_tap_bad !== 0 || r_gate_bad !== 0 || r_reads !== NTAPS * SAMPLES) begin
                bad++; $display("FAIL rand_run n=%0d done=%0d tap_bad=%0d gen_bad=%0d reads=%0d", n, r_done_cnt, r_tap_bad, r_gate_bad, r_reads);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [LANES-1:0] e_err;
        set_window(0, 3, 4);
        set_window(1, 6, 7);
        model_run(1'b0, e_err);
        run_training(1'b0, 1'b1, -1, 1'b1);
        total += 2;
        if (r_done_cnt !== 1 || r_reads !== NTAPS * SAMPLES) begin bad++; $display("FAIL start_while_busy done_cnt=%0d reads=%0d want=1,%0d", r_done_cnt, r_reads, NTAPS * SAMPLES); end
        if (rdlvl_delay !== {3'd6, 3'd3} || r_error !== e_err) begin bad++; $display("FAIL b2b_codes got=%h err=%b want=%h", rdlvl_delay, r_error, {3'd6, 3'd3}); end
    endtask

    task automatic test_reset_mid_run;
        logic [LANES-1:0] e_err;
        set_window(0, 2, 6);
        set_window(1, 5, 5);
        run_training(1'b1, 1'b1, 4 * SAMPLES, 1'b0);
        total++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL abort_point req=%b busy=%b want=1,1", rd_req, busy); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({rd_req, busy, done, rdlvl_gate_en, error, rdlvl_delay, rdlvl_gate_dly} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run got req=%b busy=%b done=%b gen=%b err=%b dly=%h gate=%h want all 0",
                     rd_req, busy, done, rdlvl_gate_en, error, rdlvl_delay, rdlvl_gate_dly);
        end
        for (int l = 0; l < LANES; l++) begin exp_dly[l] = 0; exp_gate[l] = 0; end
        @(posedge clk); #1 reset = 1'b0;
        model_run(1'b0, e_err);
        run_training(1'b0, 1'b1, -1, 1'b0);
        total += 2;
        if (r_reads !== NTAPS * SAMPLES || r_tap_bad !== 0) begin bad++; $display("FAIL post_reset_sweep reads=%0d tap_bad=%0d want=%0d,0", r_reads, r_tap_bad, NTAPS * SAMPLES); end
        if (rdlvl_delay !== {3'd5, 3'd4} || rdlvl_gate_dly !== '0 || r_error !== e_err) begin
            bad++; $display("FAIL post_reset_codes dly=%h gate=%h err=%b want=%h,0,%b", rdlvl_delay, rdlvl_gate_dly, r_error, {3'd5, 3'd4}, e_err);
        end
    endtask

    initial begin
        test_reset();
        test_data_window();
        test_gate_window();
        test_lane_fail();
        test_timeout();
        test_first_window();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
